// File: rtl/sobel_pkg.sv
// Shared sizing, FSM encoding and 3x3 tap indices for the Sobel frame controller.
package sobel_pkg;

  localparam int MAX_DIM = 1023;
  localparam int COORD_W = $clog2(MAX_DIM + 1);
  localparam int CNT_W   = $clog2(MAX_DIM * MAX_DIM);
  localparam int LEAD_W  = $clog2(MAX_DIM + 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_e;

  // Row-major window taps, d0 top-left through d8 bottom-right.
  typedef enum logic [3:0] {
    TAP_D0, TAP_D1, TAP_D2,
    TAP_D3, TAP_D4, TAP_D5,
    TAP_D6, TAP_D7, TAP_D8
  } tap_e;

  function automatic logic [8:0] pad_mask(input logic [COORD_W-1:0] row,
                                          input logic [COORD_W-1:0] col,
                                          input logic [COORD_W-1:0] last_row,
                                          input logic [COORD_W-1:0] last_col);
    logic [8:0] m;
    m = '0;
    if (row == '0) begin
      m[TAP_D0] = 1'b1; m[TAP_D1] = 1'b1; m[TAP_D2] = 1'b1;
    end
    if (row == last_row) begin
      m[TAP_D6] = 1'b1; m[TAP_D7] = 1'b1; m[TAP_D8] = 1'b1;
    end
    if (col == '0) begin
      m[TAP_D0] = 1'b1; m[TAP_D3] = 1'b1; m[TAP_D6] = 1'b1;
    end
    if (col == last_col) begin
      m[TAP_D2] = 1'b1; m[TAP_D5] = 1'b1; m[TAP_D8] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/sobel_pos_tracker.sv
// Centre coordinate and border pad mask of the window that just completed.
module sobel_pos_tracker
  import sobel_pkg::*;
#(
  parameter int ROWS = 240,
  parameter int COLS = 320
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  input  logic               clear,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic [8:0]         mask
);

  localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(ROWS - 1);
  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(COLS - 1);

  // nrow/ncol point at the next window to complete; row/col/mask present the last one.
  logic [COORD_W-1:0] nrow_q, nrow_d, ncol_q, ncol_d;
  logic [COORD_W-1:0] row_q, row_d, col_q, col_d;
  logic [8:0]         mask_q, mask_d;

  always_comb begin
    nrow_d = nrow_q;
    ncol_d = ncol_q;
    row_d  = row_q;
    col_d  = col_q;
    mask_d = mask_q;
    if (clear) begin
      nrow_d = '0;
      ncol_d = '0;
      row_d  = '0;
      col_d  = '0;
      mask_d = '0;
    end else if (step) begin
      row_d  = nrow_q;
      col_d  = ncol_q;
      mask_d = pad_mask(nrow_q, ncol_q, ROW_LAST, COL_LAST);
      if (ncol_q == COL_LAST) begin
        ncol_d = '0;
        nrow_d = (nrow_q == ROW_LAST) ? '0 : nrow_q + 1'b1;
      end else begin
        ncol_d = ncol_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nrow_q <= '0;
      ncol_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
      mask_q <= '0;
    end else begin
      nrow_q <= nrow_d;
      ncol_q <= ncol_d;
      row_q  <= row_d;
      col_q  <= col_d;
      mask_q <= mask_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign mask = mask_q;

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for a 3x3 Sobel datapath: pixel intake, line-buffer drain and window tagging.
// state    | meaning
// ST_IDLE  | waiting for start_i
// ST_RUN   | accepting ROWS*COLS pixels
// ST_FLUSH | COLS+1 zero-injecting drain shifts
// ST_DONE  | one-cycle end-of-frame pulse
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int ROWS = 240,
  parameter int COLS = 320
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               pix_valid_i,
  output logic               pix_ready_o,
  input  logic               out_ready_i,
  output logic               shift_en_o,
  output logic               flush_o,
  output logic               win_valid_o,
  output logic [8:0]         pad_mask_o,
  output logic [COORD_W-1:0] out_row_o,
  output logic [COORD_W-1:0] out_col_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [CNT_W-1:0]   LAST_PIX   = CNT_W'(ROWS * COLS - 1);
  localparam logic [LEAD_W-1:0]  LEAD_INIT  = LEAD_W'(COLS + 1);
  localparam logic [COORD_W-1:0] FLUSH_INIT = COORD_W'(COLS);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
  logic [LEAD_W-1:0]  lead_q, lead_d;
  logic [COORD_W-1:0] flush_q, flush_d;
  logic               win_valid_q, win_valid_d;
  logic               shift, complete, clear;

  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    lead_d   = lead_q;
    flush_d  = flush_q;
    clear    = 1'b0;
    shift    = out_ready_i && ((state_q == ST_RUN && pix_valid_i) || state_q == ST_FLUSH);
    // Windows start completing once the first COLS+1 shifts have primed the line buffers.
    complete = shift && (lead_q == '0);
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_RUN;
          in_cnt_d = '0;
          lead_d   = LEAD_INIT;
          flush_d  = FLUSH_INIT;
          clear    = 1'b1;
        end
      end
      ST_RUN: begin
        if (shift) begin
          if (in_cnt_q == LAST_PIX) state_d = ST_FLUSH;
          else                      in_cnt_d = in_cnt_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        if (shift) begin
          if (flush_q == '0) state_d = ST_DONE;
          else               flush_d = flush_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (shift && lead_q != '0) lead_d = lead_q - 1'b1;
    win_valid_d = complete;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      in_cnt_q    <= '0;
      lead_q      <= '0;
      flush_q     <= '0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      lead_q      <= lead_d;
      flush_q     <= flush_d;
      win_valid_q <= win_valid_d;
    end
  end

  sobel_pos_tracker #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_pos (
    .clk   (clk),
    .rst   (rst),
    .step  (complete),
    .clear (clear),
    .row   (out_row_o),
    .col   (out_col_o),
    .mask  (pad_mask_o)
  );

  assign pix_ready_o = (state_q == ST_RUN) && out_ready_i;
  assign shift_en_o  = shift;
  assign flush_o     = shift && (state_q == ST_FLUSH);
  assign win_valid_o = win_valid_q;
  assign busy_o      = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Self-checking bench for sobel_frame_ctrl on a 3x4 frame: scenario table plus scoreboard of windows.
module tb_sobel_frame_ctrl;

  localparam int ROWS = 3;
  localparam int COLS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_i = 1'b0;
  logic       pix_valid_i = 1'b0;
  logic       out_ready_i = 1'b0;
  logic       pix_ready_o, shift_en_o, flush_o, win_valid_o, busy_o, done_o;
  logic [8:0] pad_mask_o;
  logic [9:0] out_row_o, out_col_o;

  sobel_frame_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .pix_valid_i (pix_valid_i),
    .pix_ready_o (pix_ready_o),
    .out_ready_i (out_ready_i),
    .shift_en_o  (shift_en_o),
    .flush_o     (flush_o),
    .win_valid_o (win_valid_o),
    .pad_mask_o  (pad_mask_o),
    .out_row_o   (out_row_o),
    .out_col_o   (out_col_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int row;
    int col;
    int mask;
  } win_t;

  typedef struct {
    int mode;       // 0: pix_valid_i always high, 1: high on even cycles only
    int stall_at;   // cycle index of a 3-cycle out_ready_i drop, -1 for none
    int exp_wins;
    int exp_shifts;
    int exp_flush;
    int exp_first;  // shifts seen before the first win_valid_o
  } vec_t;

  win_t exp_win[12];
  vec_t vecs[4];
  win_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_shift, n_flush, n_win, n_done, first_win_shifts;
  bit last_flush, done_after_flush;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_stats();
    n_shift = 0; n_flush = 0; n_win = 0; n_done = 0;
    first_win_shifts = -1; last_flush = 0; done_after_flush = 0;
  endtask

  task automatic push_frame();
    for (int i = 0; i < 12; i++) sb.push_back(exp_win[i]);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pix_ready"}, int'(pix_ready_o), 0);
    chk({tag, "_shift_en"},  int'(shift_en_o),  0);
    chk({tag, "_flush"},     int'(flush_o),     0);
    chk({tag, "_win_valid"}, int'(win_valid_o), 0);
    chk({tag, "_pad_mask"},  int'(pad_mask_o),  0);
    chk({tag, "_row"},       int'(out_row_o),   0);
    chk({tag, "_col"},       int'(out_col_o),   0);
    chk({tag, "_busy"},      int'(busy_o),      0);
    chk({tag, "_done"},      int'(done_o),      0);
  endtask

  // Monitor: pops the scoreboard on every window and tallies shifts/done.
  always @(negedge clk) begin
    if (win_valid_o) begin
      if (n_win == 0) first_win_shifts = n_shift;
      n_win++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_extra: window (%0d,%0d) with no expected entry", out_row_o, out_col_o);
      end else begin
        win_t e;
        e = sb.pop_front();
        chk("win_row",  int'(out_row_o),  e.row);
        chk("win_col",  int'(out_col_o),  e.col);
        chk("win_mask", int'(pad_mask_o), e.mask);
      end
    end
    if (done_o) begin
      n_done++;
      done_after_flush = last_flush;
    end
    if (shift_en_o) begin
      n_shift++;
      if (flush_o) n_flush++;
    end
    last_flush = shift_en_o && flush_o;
  end

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    logic [9:0] snap_row, snap_col;
    logic [8:0] snap_mask;
    int cyc;
    clear_stats();
    sb.delete();
    push_frame();
    pulse_start();
    for (cyc = 0; cyc < 200 && n_done == 0; cyc++) begin
      pix_valid_i = (v.mode == 0) ? 1'b1 : (cyc % 2 == 0);
      out_ready_i = !(v.stall_at >= 0 && cyc >= v.stall_at && cyc < v.stall_at + 3);
      @(negedge clk);
      if (v.stall_at >= 0 && cyc >= v.stall_at && cyc < v.stall_at + 3) begin
        chk("stall_pix_ready", int'(pix_ready_o), 0);
        chk("stall_shift_en",  int'(shift_en_o),  0);
        if (cyc == v.stall_at) begin
          snap_row = out_row_o; snap_col = out_col_o; snap_mask = pad_mask_o;
        end else begin
          chk("stall_row",       int'(out_row_o),   int'(snap_row));
          chk("stall_col",       int'(out_col_o),   int'(snap_col));
          chk("stall_mask",      int'(pad_mask_o),  int'(snap_mask));
          chk("stall_win_valid", int'(win_valid_o), 0);
        end
      end
      @(posedge clk); #1;
    end
    pix_valid_i = 1'b0;
    out_ready_i = 1'b0;
    chk("frame_done_count", n_done,           1);
    chk("frame_windows",    n_win,            v.exp_wins);
    chk("frame_shifts",     n_shift,          v.exp_shifts);
    chk("frame_flush",      n_flush,          v.exp_flush);
    chk("first_win_lat",    first_win_shifts, v.exp_first);
    chk("done_after_flush", int'(done_after_flush), 1);
    chk("sb_empty",         sb.size(),        0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 3x4 frame, row-major; corners combine the row and column pad taps.
    exp_win[0]  = '{0, 0, 'h04F}; exp_win[1]  = '{0, 1, 'h007};
    exp_win[2]  = '{0, 2, 'h007}; exp_win[3]  = '{0, 3, 'h127};
    exp_win[4]  = '{1, 0, 'h049}; exp_win[5]  = '{1, 1, 'h000};
    exp_win[6]  = '{1, 2, 'h000}; exp_win[7]  = '{1, 3, 'h124};
    exp_win[8]  = '{2, 0, 'h1C9}; exp_win[9]  = '{2, 1, 'h1C0};
    exp_win[10] = '{2, 2, 'h1C0}; exp_win[11] = '{2, 3, 'h1E4};

    vecs[0] = '{0, -1, 12, 17, 5, 6};
    vecs[1] = '{1, -1, 12, 17, 5, 6};
    vecs[2] = '{0,  6, 12, 17, 5, 6};
    vecs[3] = '{1,  9, 12, 17, 5, 6};

    clear_stats();
    #12;
    check_all_zero("reset");
    #6 rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("post_release");

    for (int i = 0; i < 4; i++) run_frame(vecs[i]);

    // Reset during FLUSH: outputs drop at once and no done_o escapes.
    clear_stats();
    sb.delete();
    push_frame();
    pulse_start();
    pix_valid_i = 1'b1;
    out_ready_i = 1'b1;
    for (int i = 0; i < 50 && !flush_o; i++) @(negedge clk);
    chk("reached_flush", int'(flush_o), 1);
    #2 rst = 1'b0;
    #1 check_all_zero("mid_flush_rst");
    pix_valid_i = 1'b0;
    out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #3 chk("rst_no_done", n_done, 0);
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    run_frame(vecs[0]);

    // start_i held high: exactly one frame, then a new one from the cycle after done_o.
    clear_stats();
    sb.delete();
    push_frame();
    push_frame();
    start_i = 1'b1;
    pix_valid_i = 1'b1;
    out_ready_i = 1'b1;
    for (int i = 0; i < 100 && n_done < 1; i++) begin
      @(posedge clk); #1;
    end
    chk("held_first_shifts", n_shift, 17);
    chk("held_first_wins",   n_win,   12);
    chk("held_idle_busy",    int'(busy_o), 0);
    @(posedge clk); #1;
    chk("held_restart_busy", int'(busy_o), 1);
    start_i = 1'b0;
    for (int i = 0; i < 100 && n_done < 2; i++) begin
      @(posedge clk); #1;
    end
    chk("held_total_done",   n_done,  2);
    chk("held_total_shifts", n_shift, 34);
    chk("held_total_wins",   n_win,   24);
    chk("held_sb_empty",     sb.size(), 0);
    pix_valid_i = 1'b0;
    out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("final_idle_busy", int'(busy_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
